// File: rtl/mc_pkg.sv
// -----------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multi-cycle controller mc_ctrl:
//   opcode_t   - 3-bit ALU/instruction opcode
//   state_t    - controller FSM states
//   instr_t    - instruction word layout {op, rs, rt}
//   HALT_INSTR - instruction word that stops execution
//   BR_LUT     - branch target table indexed by the rt field of a taken beq
// -----------------------------------------------------------------------------
package mc_pkg;

    localparam int PC_W   = 10;
    localparam int CNT_W  = 16;
    localparam int DATA_W = 8;
    localparam int INSTR_W = 9;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_AND   = 3'b001,
        OP_XOR   = 3'b010,
        OP_BEQ   = 3'b011,
        OP_MOVE  = 3'b100,
        OP_LOAD  = 3'b101,
        OP_STORE = 3'b110,
        OP_RTL   = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    typedef struct packed {
        opcode_t    op;
        logic [2:0] rs;
        logic [2:0] rt;
    } instr_t;

    localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;

    // Entry i is the target of a taken beq whose rt field is i.
    // Leftmost element is index 7, rightmost is index 0.
    localparam logic [7:0][PC_W-1:0] BR_LUT = {
        10'h3FF,    // 7
        10'h0F0,    // 6
        10'h0C0,    // 5
        10'h090,    // 4
        10'h060,    // 3
        10'h030,    // 2
        10'h010,    // 1
        10'h008     // 0
    };

endpackage

// File: rtl/mc_if.sv
// -----------------------------------------------------------------------------
// mc_if
// Bundles every non-clock/reset signal of mc_ctrl.
//   master : the controller side (drives addresses, enables, ALU controls)
//   slave  : the environment side (memories, register file, ALU)
// Signals:
//   start, instr_addr/instr_data      - control and instruction memory
//   ra_a/ra_b, rf_a/rf_b               - register-file read ports
//   alu_cmd/alu_a/alu_b, alu_rslt/zero - ALU
//   rf_we/rf_wa/rf_wd                  - register-file write port
//   dm_addr/dm_we/dm_wdata/dm_rdata    - data memory
//   busy, done, instr_cnt, z_flag      - status (z_flag = last latched ALU zero)
// -----------------------------------------------------------------------------
interface mc_if;
    import mc_pkg::*;

    logic                 start;
    logic [PC_W-1:0]      instr_addr;
    logic [INSTR_W-1:0]   instr_data;
    logic [2:0]           ra_a;
    logic [2:0]           ra_b;
    logic [DATA_W-1:0]    rf_a;
    logic [DATA_W-1:0]    rf_b;
    logic [2:0]           alu_cmd;
    logic [DATA_W-1:0]    alu_a;
    logic [DATA_W-1:0]    alu_b;
    logic [DATA_W-1:0]    alu_rslt;
    logic                 alu_zero;
    logic                 rf_we;
    logic [2:0]           rf_wa;
    logic [DATA_W-1:0]    rf_wd;
    logic [DATA_W-1:0]    dm_addr;
    logic                 dm_we;
    logic [DATA_W-1:0]    dm_wdata;
    logic [DATA_W-1:0]    dm_rdata;
    logic                 busy;
    logic                 done;
    logic [CNT_W-1:0]     instr_cnt;
    logic                 z_flag;

    modport master (
        input  start, instr_data, rf_a, rf_b, alu_rslt, alu_zero, dm_rdata,
        output instr_addr, ra_a, ra_b, alu_cmd, alu_a, alu_b,
               rf_we, rf_wa, rf_wd, dm_addr, dm_we, dm_wdata,
               busy, done, instr_cnt, z_flag
    );

    modport slave (
        output start, instr_data, rf_a, rf_b, alu_rslt, alu_zero, dm_rdata,
        input  instr_addr, ra_a, ra_b, alu_cmd, alu_a, alu_b,
               rf_we, rf_wa, rf_wd, dm_addr, dm_we, dm_wdata,
               busy, done, instr_cnt, z_flag
    );

endinterface

// File: rtl/mc_ctrl_prog_ctr.sv
// -----------------------------------------------------------------------------
// prog_ctr
// Program counter and retired-instruction counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : PC and count to zero (has priority)
//   load       : PC <= load_val, counts one retirement (taken branch)
//   inc        : PC <= PC + 1 (wraps 3FF->0), counts one retirement
//   pc, cnt    : current PC and saturating retirement count
// -----------------------------------------------------------------------------
module prog_ctr
    import mc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             load,
    input  logic [PC_W-1:0]  load_val,
    input  logic             clr,
    output logic [PC_W-1:0]  pc,
    output logic [CNT_W-1:0] cnt
);

    logic [PC_W-1:0]  pc_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Every PC update other than clr marks the retirement of one instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg  <= '0;
            cnt_reg <= '0;
        end else if (clr) begin
            pc_reg  <= '0;
            cnt_reg <= '0;
        end else begin
            if (load) begin
                pc_reg <= load_val;
            end else if (inc) begin
                pc_reg <= pc_reg + 1'b1;
            end
            if ((inc || load) && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign pc  = pc_reg;
    assign cnt = cnt_reg;

endmodule

// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl
// Multi-cycle controller: FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mc_if.master (memories, register file, ALU, status)
// Latencies: ALU/move 4, load 5, store 4, beq 3, halt 2 cycles to HALT.
// All outputs are decoded from the registered state, so an asserted reset
// forces IDLE and therefore drives every output to zero immediately.
// -----------------------------------------------------------------------------
module mc_ctrl
    import mc_pkg::*;
(
    input logic clk,
    input logic rst_n,
    mc_if.master bus
);

    state_t             state_reg, state_next;
    instr_t             ir_reg;
    logic [DATA_W-1:0]  res_reg, a_reg, b_reg;
    logic               z_reg;

    logic               ir_load, exec_latch;
    logic               pc_inc, pc_load, pc_clr;
    logic [PC_W-1:0]    pc, pc_load_val;
    logic [CNT_W-1:0]   cnt;

    logic [PC_W-1:0]    instr_addr_c;
    logic [2:0]         ra_a_c, ra_b_c, alu_cmd_c, rf_wa_c;
    logic [DATA_W-1:0]  alu_a_c, alu_b_c, rf_wd_c, dm_addr_c, dm_wdata_c;
    logic               rf_we_c, dm_we_c, busy_c, done_c;

    prog_ctr u_prog_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (pc_inc),
        .load     (pc_load),
        .load_val (pc_load_val),
        .clr      (pc_clr),
        .pc       (pc),
        .cnt      (cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_reg  <= '0;
            res_reg <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            z_reg   <= 1'b0;
        end else begin
            if (ir_load) begin
                ir_reg <= instr_t'(bus.instr_data);
            end
            if (exec_latch) begin
                res_reg <= bus.alu_rslt;
                z_reg   <= bus.alu_zero;
                a_reg   <= bus.rf_a;
                b_reg   <= bus.rf_b;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        ir_load      = 1'b0;
        exec_latch   = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        pc_clr       = 1'b0;
        pc_load_val  = BR_LUT[ir_reg.rt];
        instr_addr_c = '0;
        ra_a_c       = '0;
        ra_b_c       = '0;
        alu_cmd_c    = '0;
        alu_a_c      = '0;
        alu_b_c      = '0;
        rf_we_c      = 1'b0;
        rf_wa_c      = '0;
        rf_wd_c      = '0;
        dm_addr_c    = '0;
        dm_we_c      = 1'b0;
        dm_wdata_c   = '0;
        busy_c       = 1'b0;
        done_c       = 1'b0;

        case (state_reg)
            ST_IDLE, ST_HALT: begin
                done_c = (state_reg == ST_HALT);
                if (bus.start) begin
                    pc_clr     = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                busy_c       = 1'b1;
                instr_addr_c = pc;
                state_next   = ST_DECODE;
            end
            ST_DECODE: begin
                // Instruction memory returns the word fetched last cycle.
                busy_c     = 1'b1;
                ir_load    = 1'b1;
                state_next = (bus.instr_data == HALT_INSTR) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                busy_c     = 1'b1;
                exec_latch = 1'b1;
                ra_a_c     = ir_reg.rs;
                ra_b_c     = ir_reg.rt;
                alu_cmd_c  = ir_reg.op;
                alu_a_c    = bus.rf_a;
                alu_b_c    = bus.rf_b;
                case (ir_reg.op)
                    OP_BEQ: begin
                        // Branch resolves on the live ALU flag; beq retires here.
                        state_next = ST_FETCH;
                        if (bus.alu_zero) begin
                            pc_load = 1'b1;
                        end else begin
                            pc_inc = 1'b1;
                        end
                    end
                    OP_LOAD, OP_STORE: state_next = ST_MEM;
                    default:           state_next = ST_WB;
                endcase
            end
            ST_MEM: begin
                busy_c    = 1'b1;
                dm_addr_c = b_reg;
                if (ir_reg.op == OP_STORE) begin
                    dm_we_c    = 1'b1;
                    dm_wdata_c = a_reg;
                    pc_inc     = 1'b1;
                    state_next = ST_FETCH;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_WB: begin
                busy_c     = 1'b1;
                rf_we_c    = 1'b1;
                rf_wa_c    = ir_reg.rs;
                rf_wd_c    = (ir_reg.op == OP_LOAD) ? bus.dm_rdata : res_reg;
                pc_inc     = 1'b1;
                state_next = ST_FETCH;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.instr_addr = instr_addr_c;
    assign bus.ra_a       = ra_a_c;
    assign bus.ra_b       = ra_b_c;
    assign bus.alu_cmd    = alu_cmd_c;
    assign bus.alu_a      = alu_a_c;
    assign bus.alu_b      = alu_b_c;
    assign bus.rf_we      = rf_we_c;
    assign bus.rf_wa      = rf_wa_c;
    assign bus.rf_wd      = rf_wd_c;
    assign bus.dm_addr    = dm_addr_c;
    assign bus.dm_we      = dm_we_c;
    assign bus.dm_wdata   = dm_wdata_c;
    assign bus.busy       = busy_c;
    assign bus.done       = done_c;
    assign bus.instr_cnt  = cnt;
    assign bus.z_flag     = z_reg;

endmodule

// File: tb/tb_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl
// Drives mc_ctrl with behavioural instruction/data memories, a register file
// and an ALU. Expected register/data-memory writes are queued before each
// program runs and are consumed as the controller issues them.
// -----------------------------------------------------------------------------
module tb_mc_ctrl;

    logic clk;
    logic rst_n;

    mc_if bus();

    mc_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent copy of the branch target table.
    logic [9:0] exp_lut [8];

    // Environment models
    logic [8:0] imem [1024];
    logic [7:0] dmem [256];
    logic [7:0] rf   [8];

    logic       tb_rf_we, tb_dm_we;
    logic [2:0] tb_rf_wa;
    logic [7:0] tb_rf_wd, tb_dm_wa, tb_dm_wd;

    assign bus.rf_a = rf[bus.ra_a];
    assign bus.rf_b = rf[bus.ra_b];

    always_comb begin
        case (bus.alu_cmd)
            3'b000:  bus.alu_rslt = bus.alu_a + bus.alu_b;
            3'b001:  bus.alu_rslt = bus.alu_a & bus.alu_b;
            3'b010:  bus.alu_rslt = bus.alu_a ^ bus.alu_b;
            3'b011:  bus.alu_rslt = bus.alu_a - bus.alu_b;
            3'b100:  bus.alu_rslt = bus.alu_b;
            3'b111:  bus.alu_rslt = {bus.alu_a[6:0], bus.alu_a[7]};
            default: bus.alu_rslt = bus.alu_a;
        endcase
        bus.alu_zero = (bus.alu_a == bus.alu_b);
    end

    always @(posedge clk) begin
        bus.instr_data <= imem[bus.instr_addr];
        bus.dm_rdata   <= dmem[bus.dm_addr];
        if (bus.rf_we)      rf[bus.rf_wa]   <= bus.rf_wd;
        else if (tb_rf_we)  rf[tb_rf_wa]    <= tb_rf_wd;
        if (bus.dm_we)      dmem[bus.dm_addr] <= bus.dm_wdata;
        else if (tb_dm_we)  dmem[tb_dm_wa]    <= tb_dm_wd;
    end

    typedef struct {
        bit         is_dm;
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    // Consume one expected write per write pulse seen on the bus.
    task automatic sb_monitor();
        wr_t        exp_w;
        logic [7:0] act_addr, act_data;
        if (bus.rf_we || bus.dm_we) begin
            n_checks++;
            if (bus.rf_we && bus.dm_we) begin
                n_fail++;
                $display("FAIL both_we: got rf_we=%0b dm_we=%0b required not both", bus.rf_we, bus.dm_we);
            end
            act_addr = bus.dm_we ? bus.dm_addr  : {5'b0, bus.rf_wa};
            act_data = bus.dm_we ? bus.dm_wdata : bus.rf_wd;
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got dm=%0b addr=%0h data=%0h required none", bus.dm_we, act_addr, act_data);
            end else begin
                exp_w = sb_q.pop_front();
                if (exp_w.is_dm != bus.dm_we || act_addr !== exp_w.addr || act_data !== exp_w.data) begin
                    n_fail++;
                    $display("FAIL sb_write: got dm=%0b addr=%0h data=%0h required dm=%0b addr=%0h data=%0h",
                             bus.dm_we, act_addr, act_data, exp_w.is_dm, exp_w.addr, exp_w.data);
                end else begin
                    $display("write %s addr=%0h data=%0h matched", bus.dm_we ? "dmem" : "rf", act_addr, act_data);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        sb_monitor();
    endtask

    task automatic set_reg(input logic [2:0] a, input logic [7:0] d);
        tb_rf_we = 1'b1; tb_rf_wa = a; tb_rf_wd = d;
        tick();
        tb_rf_we = 1'b0;
    endtask

    task automatic set_dmem(input logic [7:0] a, input logic [7:0] d);
        tb_dm_we = 1'b1; tb_dm_wa = a; tb_dm_wd = d;
        tick();
        tb_dm_we = 1'b0;
    endtask

    task automatic push_rf(input logic [2:0] a, input logic [7:0] d);
        wr_t w;
        w.is_dm = 1'b0; w.addr = {5'b0, a}; w.data = d;
        sb_q.push_back(w);
    endtask

    task automatic push_dm(input logic [7:0] a, input logic [7:0] d);
        wr_t w;
        w.is_dm = 1'b1; w.addr = a; w.data = d;
        sb_q.push_back(w);
    endtask

    // Returns one cycle into FETCH (cycle 1 of the program).
    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b required 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0b required 0", bus.done); end
        n_checks++; if (bus.rf_we !== 1'b0 || bus.dm_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got rf_we=%0b dm_we=%0b required 0", bus.rf_we, bus.dm_we); end
        n_checks++; if (bus.instr_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_cnt: got %0h required 0", bus.instr_cnt); end
        n_checks++; if (bus.instr_addr !== 10'h0 || bus.dm_addr !== 8'h0 || bus.alu_cmd !== 3'h0) begin n_fail++; $display("FAIL rst_addr: got ia=%0h da=%0h cmd=%0h required 0", bus.instr_addr, bus.dm_addr, bus.alu_cmd); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        imem[0] = 9'b000_001_010;   // add r1 r2
        imem[1] = 9'h1FF;
        set_reg(3'd1, 8'h03);
        set_reg(3'd2, 8'h04);
        push_rf(3'd1, 8'h07);
        pulse_start();
        n_checks++; if (bus.instr_addr !== 10'h000 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL alu_fetch: got addr=%0h busy=%0b required 0/1", bus.instr_addr, bus.busy); end
        tick(); tick();
        n_checks++; if (bus.ra_a !== 3'd1 || bus.ra_b !== 3'd2 || bus.alu_cmd !== 3'b000) begin n_fail++; $display("FAIL alu_exec_ctl: got ra_a=%0h ra_b=%0h cmd=%0h required 1/2/0", bus.ra_a, bus.ra_b, bus.alu_cmd); end
        n_checks++; if (bus.alu_a !== 8'h03 || bus.alu_b !== 8'h04) begin n_fail++; $display("FAIL alu_operands: got %0h/%0h required 3/4", bus.alu_a, bus.alu_b); end
        tick();
        n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_wa !== 3'd1 || bus.rf_wd !== 8'h07) begin n_fail++; $display("FAIL alu_wb_c4: got we=%0b wa=%0h wd=%0h required 1/1/07", bus.rf_we, bus.rf_wa, bus.rf_wd); end
        n_checks++; if (bus.instr_cnt !== 16'd0) begin n_fail++; $display("FAIL alu_cnt_wb: got %0d required 0", bus.instr_cnt); end
        tick();
        n_checks++; if (bus.instr_addr !== 10'h001 || bus.instr_cnt !== 16'd1) begin n_fail++; $display("FAIL alu_next: got addr=%0h cnt=%0d required 1/1", bus.instr_addr, bus.instr_cnt); end
        tick(); tick();
        n_checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL alu_halt: got done=%0b busy=%0b required 1/0", bus.done, bus.busy); end
    endtask

    task automatic test_load();
        imem[0] = 9'b101_011_100;   // load r3 r4
        imem[1] = 9'h1FF;
        set_reg(3'd4, 8'h10);
        set_dmem(8'h10, 8'hA5);
        push_rf(3'd3, 8'hA5);
        pulse_start();
        n_checks++; if (bus.instr_addr !== 10'h000 || bus.instr_cnt !== 16'd0) begin n_fail++; $display("FAIL load_restart: got addr=%0h cnt=%0d required 0/0", bus.instr_addr, bus.instr_cnt); end
        tick(); tick(); tick();
        n_checks++; if (bus.dm_addr !== 8'h10 || bus.dm_we !== 1'b0 || bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL load_mem: got dm_addr=%0h dm_we=%0b rf_we=%0b required 10/0/0", bus.dm_addr, bus.dm_we, bus.rf_we); end
        tick();
        n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_wa !== 3'd3 || bus.rf_wd !== 8'hA5) begin n_fail++; $display("FAIL load_wb_c5: got we=%0b wa=%0h wd=%0h required 1/3/A5", bus.rf_we, bus.rf_wa, bus.rf_wd); end
        tick();
        n_checks++; if (bus.instr_addr !== 10'h001 || bus.instr_cnt !== 16'd1) begin n_fail++; $display("FAIL load_next: got addr=%0h cnt=%0d required 1/1", bus.instr_addr, bus.instr_cnt); end
        tick(); tick();
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL load_halt: got done=%0b required 1", bus.done); end
    endtask

    task automatic test_store();
        imem[0] = 9'b110_101_110;   // store r5 r6
        imem[1] = 9'h1FF;
        set_reg(3'd5, 8'h3C);
        set_reg(3'd6, 8'h20);
        push_dm(8'h20, 8'h3C);
        pulse_start();
        tick(); tick(); tick();
        n_checks++; if (bus.dm_we !== 1'b1 || bus.dm_addr !== 8'h20 || bus.dm_wdata !== 8'h3C) begin n_fail++; $display("FAIL store_mem: got we=%0b addr=%0h data=%0h required 1/20/3C", bus.dm_we, bus.dm_addr, bus.dm_wdata); end
        n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL store_no_rf: got rf_we=%0b required 0", bus.rf_we); end
        tick();
        n_checks++; if (bus.dm_we !== 1'b0 || bus.instr_addr !== 10'h001 || bus.instr_cnt !== 16'd1) begin n_fail++; $display("FAIL store_next: got we=%0b addr=%0h cnt=%0d required 0/1/1", bus.dm_we, bus.instr_addr, bus.instr_cnt); end
        tick(); tick();
        n_checks++; if (bus.done !== 1'b1 || dmem[8'h20] !== 8'h3C) begin n_fail++; $display("FAIL store_result: got done=%0b dmem=%0h required 1/3C", bus.done, dmem[8'h20]); end
    endtask

    task automatic test_beq();
        imem[0]      = 9'b011_001_010;  // beq r1 r2 (equal, taken)
        imem[10'h030] = 9'b011_011_010; // beq r3 r2 (not equal)
        imem[10'h031] = 9'h1FF;
        set_reg(3'd1, 8'h09);
        set_reg(3'd2, 8'h09);
        set_reg(3'd3, 8'h01);
        pulse_start();
        tick(); tick();
        n_checks++; if (bus.alu_cmd !== 3'b011) begin n_fail++; $display("FAIL beq_cmd: got %0h required 3", bus.alu_cmd); end
        tick();
        n_checks++; if (bus.instr_addr !== exp_lut[2] || bus.instr_cnt !== 16'd1 || bus.z_flag !== 1'b1) begin n_fail++; $display("FAIL beq_taken: got addr=%0h cnt=%0d z=%0b required %0h/1/1", bus.instr_addr, bus.instr_cnt, bus.z_flag, exp_lut[2]); end
        tick(); tick(); tick();
        n_checks++; if (bus.instr_addr !== exp_lut[2] + 10'd1 || bus.instr_cnt !== 16'd2 || bus.z_flag !== 1'b0) begin n_fail++; $display("FAIL beq_not_taken: got addr=%0h cnt=%0d z=%0b required %0h/2/0", bus.instr_addr, bus.instr_cnt, bus.z_flag, exp_lut[2] + 10'd1); end
        tick(); tick();
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL beq_halt: got done=%0b required 1", bus.done); end
    endtask

    task automatic test_start_ignored();
        imem[0] = 9'b000_001_010;   // add r1 r2
        imem[1] = 9'h1FF;
        set_reg(3'd1, 8'h02);
        set_reg(3'd2, 8'h05);
        push_rf(3'd1, 8'h07);
        pulse_start();
        tick();
        bus.start = 1'b1;           // held through DECODE and EXEC
        tick();
        n_checks++; if (bus.ra_a !== 3'd1 || bus.alu_cmd !== 3'b000 || bus.busy !== 1'b1 || bus.alu_b !== 8'h05) begin n_fail++; $display("FAIL ign_exec: got ra_a=%0h cmd=%0h busy=%0b b=%0h required 1/0/1/05", bus.ra_a, bus.alu_cmd, bus.busy, bus.alu_b); end
        tick();
        bus.start = 1'b0;
        n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_wd !== 8'h07) begin n_fail++; $display("FAIL ign_wb: got we=%0b wd=%0h required 1/07", bus.rf_we, bus.rf_wd); end
        tick();
        n_checks++; if (bus.instr_addr !== 10'h001 || bus.instr_cnt !== 16'd1) begin n_fail++; $display("FAIL ign_next: got addr=%0h cnt=%0d required 1/1", bus.instr_addr, bus.instr_cnt); end
        tick(); tick();
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL ign_halt: got done=%0b required 1", bus.done); end
    endtask

    task automatic test_pc_wrap();
        imem[0]       = 9'b011_001_111; // beq r1 r7 -> BR_LUT[7]
        imem[10'h3FF] = 9'b000_001_010; // add r1 r2
        imem[1]       = 9'h1FF;
        set_reg(3'd1, 8'h05);
        set_reg(3'd7, 8'h05);
        set_reg(3'd2, 8'h01);
        push_rf(3'd1, 8'h06);
        pulse_start();
        tick(); tick(); tick();
        n_checks++; if (bus.instr_addr !== exp_lut[7]) begin n_fail++; $display("FAIL wrap_branch: got addr=%0h required %0h", bus.instr_addr, exp_lut[7]); end
        tick(); tick(); tick();
        n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_wd !== 8'h06) begin n_fail++; $display("FAIL wrap_wb: got we=%0b wd=%0h required 1/06", bus.rf_we, bus.rf_wd); end
        tick();
        n_checks++; if (bus.instr_addr !== 10'h000 || bus.busy !== 1'b1 || bus.instr_cnt !== 16'd2) begin n_fail++; $display("FAIL wrap_fetch0: got addr=%0h busy=%0b cnt=%0d required 0/1/2", bus.instr_addr, bus.busy, bus.instr_cnt); end
        tick(); tick();
        n_checks++; if (bus.alu_cmd !== 3'b011 || bus.alu_a !== 8'h06 || bus.alu_b !== 8'h05) begin n_fail++; $display("FAIL wrap_exec: got cmd=%0h a=%0h b=%0h required 3/06/05", bus.alu_cmd, bus.alu_a, bus.alu_b); end
        tick();
        n_checks++; if (bus.instr_addr !== 10'h001) begin n_fail++; $display("FAIL wrap_fall: got addr=%0h required 1", bus.instr_addr); end
        tick(); tick();
        n_checks++; if (bus.done !== 1'b1 || bus.instr_cnt !== 16'd3) begin n_fail++; $display("FAIL wrap_halt: got done=%0b cnt=%0d required 1/3", bus.done, bus.instr_cnt); end
    endtask

    task automatic test_reset_mid();
        imem[0] = 9'b000_001_010;   // add r1 r2, aborted in EXEC
        set_reg(3'd1, 8'h06);
        set_reg(3'd2, 8'h01);
        pulse_start();
        tick(); tick();
        n_checks++; if (bus.ra_a !== 3'd1 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL rmid_exec: got ra_a=%0h busy=%0b required 1/1", bus.ra_a, bus.busy); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.busy !== 1'b0 || bus.ra_a !== 3'd0 || bus.alu_a !== 8'h00 || bus.alu_cmd !== 3'd0) begin n_fail++; $display("FAIL rmid_async: got busy=%0b ra_a=%0h a=%0h cmd=%0h required 0", bus.busy, bus.ra_a, bus.alu_a, bus.alu_cmd); end
        tick(); tick();
        n_checks++; if (bus.rf_we !== 1'b0 || bus.dm_we !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL rmid_hold: got rf_we=%0b dm_we=%0b done=%0b required 0", bus.rf_we, bus.dm_we, bus.done); end
        rst_n = 1'b1;
        tick(); tick();
        n_checks++; if (rf[1] !== 8'h06 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL rmid_after: got r1=%0h busy=%0b done=%0b required 06/0/0", rf[1], bus.busy, bus.done); end
    endtask

    initial begin
        exp_lut[0] = 10'h008; exp_lut[1] = 10'h010; exp_lut[2] = 10'h030; exp_lut[3] = 10'h060;
        exp_lut[4] = 10'h090; exp_lut[5] = 10'h0C0; exp_lut[6] = 10'h0F0; exp_lut[7] = 10'h3FF;
        for (int i = 0; i < 1024; i++) imem[i] = 9'h1FF;
        bus.start = 1'b0;
        tb_rf_we = 1'b0; tb_rf_wa = '0; tb_rf_wd = '0;
        tb_dm_we = 1'b0; tb_dm_wa = '0; tb_dm_wd = '0;
        rst_n = 1'b0;

        test_reset();
        test_alu();
        test_load();
        test_store();
        test_beq();
        test_start_ignored();
        test_pc_wrap();
        test_reset_mid();

        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending writes required 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
